count_sched: RTL and testbench
==============================

COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the counter.
REQ-002 Parameter CW, default 8: counter and run-length width in bits.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester count-run request; level, held until done or abort.
REQ-006 len  input  NREQ*CW  per-requester run length; slice i = len[i*CW +: CW].
REQ-007 hold  input  1  pauses counting while high (counter enable low).
REQ-008 gnt  output  NREQ  one-hot grant; high for the owner during RUN only.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 count  output  CW  current shared counter value.
REQ-011 done  output  NREQ  one-cycle one-hot pulse on run completion.
REQ-012 abort  output  NREQ  one-cycle one-hot pulse on owner request withdrawal.

Function
REQ-013 FSM states: IDLE, RUN, DONE; the block SHALL hold exactly one at all times.
REQ-014 IDLE: no req -> stay; any req -> pick winner, latch target=len[winner], clear count to 0, set gnt one-hot, go RUN.
REQ-015 Winner selection: round-robin, search starts at pointer ptr, ascending index, wrap at NREQ-1 -> 0.
REQ-016 ptr SHALL update to (winner+1) mod NREQ on entering DONE (completion or abort).
REQ-017 IDLE with latched target == 0: go DONE directly, no RUN cycle, count stays 0, done pulse issued.
REQ-018 RUN, hold=0, req[owner]=1: count increments by 1 per cycle.
REQ-019 RUN, hold=1: count holds; no transition unless abort condition.
REQ-020 RUN: increment that makes count == target -> go DONE; count ends equal to target.
REQ-021 RUN: req[owner]=0 -> go DONE with abort flag; count frozen at current value; abort takes priority over hold and completion in the same cycle.
REQ-022 DONE: lasts exactly 1 cycle; gnt=0; done[owner]=1 (or abort[owner]=1 if aborted, never both); next state IDLE.
REQ-023 Gap between consecutive grants SHALL be exactly 2 cycles (DONE + IDLE).
REQ-024 count SHALL never wrap; max target 2^CW-1 reaches 2^CW-1 and stops.
REQ-025 len and req of non-owners SHALL be ignored during RUN/DONE; len of owner sampled only at grant.
REQ-026 count SHALL remain at final value through DONE and IDLE until next grant clears it.

Reset
REQ-027 reset high SHALL immediately force: state IDLE, ptr 0, count 0, target 0, gnt 0, done 0, abort 0, busy 0.
REQ-028 reset asserted mid-RUN SHALL discard the run without done or abort pulse.
REQ-029 First grant after reset release SHALL follow IDLE rules with ptr=0.

Structure
REQ-030 Shared package count_sched_pkg SHALL hold the state enum type and the NREQ/CW default constants.
REQ-031 One sub-module rr_pick SHALL implement combinational round-robin selection (inputs req, ptr; outputs valid, one-hot winner, index).
REQ-032 Counter, target register, FSM, ptr SHALL live in count_sched; total RTL 120-400 lines.

Verification
REQ-033 req=0001, len0=5, hold=0 -> gnt=0001 for 5 RUN cycles, count 1..5, done=0001 one cycle, count stays 5.
REQ-034 req=1111 all len=2, held -> grants in order 0001,0010,0100,1000,0001; 2-cycle gap between grants.
REQ-035 req=0100, len2=0 -> no gnt, done=0100 one cycle after grant decision, count=0.
REQ-036 req=0010, len1=10; hold high 3 cycles mid-run -> run lasts 13 RUN cycles, done=0010, count=10.
REQ-037 req=0001, len0=200; drop req0 at count=7 -> abort=0001, done=0000, count frozen at 7, ptr=1.
REQ-038 reset pulse at count=3 of len=8 run -> all outputs 0 asynchronously, no done/abort, next grant starts from req index 0.

Source files
------------

// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the count_sched block.
// Holds the FSM state type and index-width helper.
package count_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_sched_rr_pick.sv
// Combinational round-robin picker.
// Scans upward from ptr, wrapping to 0.
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx
);

  // first requester at or after ptr wins
  always_comb begin
    int j;
    j      = 0;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        winner[j] = 1'b1;
        idx       = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Shared run-length counter granted round-robin.
// Owner counts to its latched target, then releases.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] len,
  input  logic             hold,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [CW-1:0]    count,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  abort
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  state_t          nstate;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   target;
  logic            aborted;

  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [CW-1:0]   pick_len;

  logic            grab;
  logic            inc;
  logic            set_abort;
  logic            enter_done;
  logic [IW-1:0]   done_idx;
  logic [IW-1:0]   ptr_nxt;
  logic [CW-1:0]   count_inc;
  logic [NREQ-1:0] own_oh;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_oh),
    .idx    (pick_idx)
  );

  // run length of the current winner
  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_len = pick_len | len[i*CW +: CW];
    end
  end

  assign count_inc = count + CW'(1);
  assign own_oh    = NREQ'(1) << owner;

  // pointer moves just past whoever is finishing
  always_comb begin
    done_idx = (state == S_IDLE) ? pick_idx : owner;
    if (int'(done_idx) == NREQ - 1) ptr_nxt = '0;
    else ptr_nxt = done_idx + IW'(1);
  end

  // next state; abort outranks hold and completion
  always_comb begin
    nstate     = state;
    grab       = 1'b0;
    inc        = 1'b0;
    set_abort  = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grab = 1'b1;
          if (pick_len == '0) begin
            nstate     = S_DONE;
            enter_done = 1'b1;
          end else begin
            nstate = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!req[owner]) begin
          nstate     = S_DONE;
          set_abort  = 1'b1;
          enter_done = 1'b1;
        end else if (!hold) begin
          inc = 1'b1;
          if (count_inc == target) begin
            nstate     = S_DONE;
            enter_done = 1'b1;
          end
        end
      end
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // state, counter, target, owner and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      owner   <= '0;
      target  <= '0;
      count   <= '0;
      aborted <= 1'b0;
    end else begin
      state <= nstate;
      if (grab) begin
        owner   <= pick_idx;
        target  <= pick_len;
        count   <= '0;
        aborted <= 1'b0;
      end
      if (inc) count <= count_inc;
      if (set_abort) aborted <= 1'b1;
      if (enter_done) ptr <= ptr_nxt;
    end
  end

  assign gnt   = (state == S_RUN) ? own_oh : '0;
  assign busy  = (state == S_RUN) || (state == S_DONE);
  assign done  = (state == S_DONE && !aborted) ? own_oh : '0;
  assign abort = (state == S_DONE && aborted) ? own_oh : '0;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched.
// Expected values are worked out by hand per step.
module tb_count_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*CW-1:0] len;
  logic             hold;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic [CW-1:0]    count;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  abort;

  int total;
  int bad;

  count_sched #(
    .NREQ (NREQ),
    .CW   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .hold  (hold),
    .gnt   (gnt),
    .busy  (busy),
    .count (count),
    .done  (done),
    .abort (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] g,
                         input logic b,
                         input logic [7:0] c,
                         input logic [3:0] d,
                         input logic [3:0] a);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".abort"}, 32'(abort), 32'(a));
  endtask

  logic [3:0] order [5];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = '0;
    len   = '0;
    hold  = 1'b0;
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    tick();
    tick();
    chk_all("rst", 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000);
    reset = 1'b0;

    // single run of length 5 from requester 0
    req = 4'b0001;
    len = {8'd0, 8'd0, 8'd0, 8'd5};
    tick();
    chk_all("r5.start", 4'b0001, 1'b1, 8'd0, 4'b0000, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("r5.gnt", 32'(gnt), 32'h1);
      chk("r5.count", 32'(count), 32'(k));
    end
    tick();
    chk_all("r5.done", 4'b0000, 1'b1, 8'd5, 4'b0001, 4'b0000);
    req = 4'b0000;
    tick();
    chk_all("r5.idle", 4'b0000, 1'b0, 8'd5, 4'b0000, 4'b0000);
    tick();
    chk("r5.keep", 32'(count), 32'd5);

    // idle reset returns the pointer to 0
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // all requesters, length 2: strict rotation, 2-cycle gap
    req = 4'b1111;
    len = {8'd2, 8'd2, 8'd2, 8'd2};
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr.g1", 32'(gnt), 32'(order[n]));
      tick();
      chk("rr.g2", 32'(gnt), 32'(order[n]));
      tick();
      chk("rr.gap1", 32'(gnt), 32'h0);
      chk("rr.done", 32'(done), 32'(order[n]));
      tick();
      chk("rr.gap2", 32'(gnt), 32'h0);
      chk("rr.cnt", 32'(count), 32'd2);
    end
    req = 4'b0000;

    // zero length: straight to DONE, no grant (ptr now 1)
    req = 4'b0100;
    len = {8'd2, 8'd0, 8'd2, 8'd2};
    tick();
    chk_all("z.done", 4'b0000, 1'b1, 8'd0, 4'b0100, 4'b0000);
    req = 4'b0000;
    tick();
    chk_all("z.idle", 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000);

    // length 10 with 3 hold cycles: 13 RUN cycles (ptr now 3)
    req = 4'b0010;
    len = {8'd0, 8'd0, 8'd10, 8'd0};
    tick();
    chk_all("h.start", 4'b0010, 1'b1, 8'd0, 4'b0000, 4'b0000);
    tick();
    tick();
    chk("h.pre", 32'(count), 32'd2);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h.held", 32'(count), 32'd2);
      chk("h.gnt", 32'(gnt), 32'h2);
    end
    hold = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk("h.count", 32'(count), 32'(k));
      chk("h.busy", 32'(busy), 32'h1);
    end
    tick();
    chk_all("h.done", 4'b0000, 1'b1, 8'd10, 4'b0010, 4'b0000);
    req = 4'b0000;
    tick();
    chk("h.idle", 32'(busy), 32'h0);

    // abort at count 7, with hold high in the same cycle (ptr now 2)
    req = 4'b0001;
    len = {8'd0, 8'd0, 8'd0, 8'd200};
    tick();
    chk("a.start", 32'(gnt), 32'h1);
    for (int k = 0; k < 7; k++) tick();
    chk("a.pre", 32'(count), 32'd7);
    req  = 4'b0000;
    hold = 1'b1;
    tick();
    chk_all("a.abort", 4'b0000, 1'b1, 8'd7, 4'b0000, 4'b0001);
    hold = 1'b0;
    tick();
    chk_all("a.idle", 4'b0000, 1'b0, 8'd7, 4'b0000, 4'b0000);

    // ptr should be 1: requesters 0 and 1 -> 1 wins
    req = 4'b0011;
    len = {8'd0, 8'd0, 8'd1, 8'd1};
    tick();
    chk("p.gnt", 32'(gnt), 32'h2);
    tick();
    chk("p.done", 32'(done), 32'h2);
    req = 4'b0000;
    tick();

    // reset mid-run at count 3 (ptr now 2)
    req = 4'b0001;
    len = {8'd0, 8'd0, 8'd0, 8'd8};
    tick();
    tick();
    tick();
    tick();
    chk("m.pre", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk_all("m.async", 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000);
    tick();
    chk_all("m.hold", 4'b0000, 1'b0, 8'd0, 4'b0000, 4'b0000);
    reset = 1'b0;
    req = 4'b0110;
    len = {8'd0, 8'd1, 8'd1, 8'd0};
    tick();
    chk("m.first", 32'(gnt), 32'h2);
    tick();
    chk("m.done", 32'(done), 32'h2);
    chk("m.abort", 32'(abort), 32'h0);
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
